// File: rtl/ray_dispatcher_if.sv
// Result channel from ray_dispatcher to the shading/framebuffer stage.
// The dispatcher is the master; px_valid/px_ready form a standard valid/ready handshake.
interface ray_dispatcher_if #(
  parameter int unsigned X_W     = 9,
  parameter int unsigned Y_W     = 8,
  parameter int unsigned COMP_W  = 32,
  parameter int unsigned BLOCK_W = 8
);
  logic [X_W-1:0]      px_x;
  logic [Y_W-1:0]      px_y;
  logic [BLOCK_W-1:0]  px_block;
  logic [3*COMP_W-1:0] px_norm;
  logic                px_valid;
  logic                px_ready;

  modport master (
    output px_x, px_y, px_block, px_norm, px_valid,
    input  px_ready
  );

  modport slave (
    input  px_x, px_y, px_block, px_norm, px_valid,
    output px_ready
  );
endinterface

// File: rtl/ray_dispatcher.sv
// Raster-order ray sequencer for a single VoxelTraversalUnit: launches one ray per pixel,
// waits for a hit or timeout, and forwards the result over a valid/ready channel.
module ray_dispatcher #(
  parameter int unsigned         WIDTH     = 320,
  parameter int unsigned         HEIGHT    = 180,
  parameter int unsigned         TIMEOUT   = 4096,
  parameter int unsigned         COMP_W    = 32,
  parameter int unsigned         BLOCK_W   = 8,
  parameter logic [BLOCK_W-1:0]  BLOCK_AIR = '0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start,
  input  logic [3*COMP_W-1:0] cam_pos,
  input  logic [3*COMP_W-1:0] cam_dir00,
  input  logic [3*COMP_W-1:0] cam_dx,
  input  logic [3*COMP_W-1:0] cam_dy,
  output logic                vtu_rst,
  output logic [3*COMP_W-1:0] ray_origin,
  output logic [3*COMP_W-1:0] ray_direction,
  input  logic [BLOCK_W-1:0]  hit,
  input  logic [3*COMP_W-1:0] hit_norm,
  input  logic                hit_valid,
  ray_dispatcher_if.master    px,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned X_W = $clog2(WIDTH);
  localparam int unsigned Y_W = $clog2(HEIGHT);
  localparam int unsigned T_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_EMIT,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [T_W-1:0]      r_tcnt;
  logic [T_W-1:0]      w_tcnt_nxt;
  logic                w_timeout;
  logic                w_last;
  logic [3*COMP_W-1:0] r_cam_pos;
  logic [3*COMP_W-1:0] r_dx;
  logic [3*COMP_W-1:0] r_dy;
  logic [3*COMP_W-1:0] r_row_dir;
  logic [3*COMP_W-1:0] r_dir;
  logic [BLOCK_W-1:0]  r_blk;
  logic [3*COMP_W-1:0] r_norm;

  // Component-wise add with two's-complement wrap.
  function automatic logic [3*COMP_W-1:0] fadd(input logic [3*COMP_W-1:0] a,
                                                input logic [3*COMP_W-1:0] b);
    logic [3*COMP_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      r[i*COMP_W +: COMP_W] = a[i*COMP_W +: COMP_W] + b[i*COMP_W +: COMP_W];
    end
    return r;
  endfunction

  assign px.px_x     = r_x;
  assign px.px_y     = r_y;
  assign px.px_block = r_blk;
  assign px.px_norm  = r_norm;

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Timeout fires on the WAIT cycle whose incremented count reaches TIMEOUT-1,
  // so a missed ray is emitted exactly TIMEOUT cycles after its vtu_rst cycle.
  always_comb begin
    w_state_nxt = r_state;
    vtu_rst     = 1'b0;
    px.px_valid = 1'b0;
    frame_done  = 1'b0;
    w_tcnt_nxt  = r_tcnt + 1'b1;
    w_timeout   = (w_tcnt_nxt == T_W'(TIMEOUT - 1));
    w_last      = (r_x == X_W'(WIDTH - 1)) && (r_y == Y_W'(HEIGHT - 1));
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        vtu_rst     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT:    if (hit_valid || w_timeout) w_state_nxt = S_EMIT;
      S_EMIT: begin
        px.px_valid = 1'b1;
        if (px.px_ready) w_state_nxt = S_ADVANCE;
      end
      S_ADVANCE: w_state_nxt = w_last ? S_DONE : S_LAUNCH;
      S_DONE: begin
        frame_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_x           <= '0;
      r_y           <= '0;
      r_tcnt        <= '0;
      r_cam_pos     <= '0;
      r_dx          <= '0;
      r_dy          <= '0;
      r_row_dir     <= '0;
      r_dir         <= '0;
      r_blk         <= BLOCK_AIR;
      r_norm        <= '0;
      ray_origin    <= '0;
      ray_direction <= '0;
      busy          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cam_pos <= cam_pos;
            r_dx      <= cam_dx;
            r_dy      <= cam_dy;
            r_row_dir <= cam_dir00;
            r_dir     <= cam_dir00;
            r_x       <= '0;
            r_y       <= '0;
            busy      <= 1'b1;
          end
        end
        S_LAUNCH: begin
          ray_origin    <= r_cam_pos;
          ray_direction <= r_dir;
          r_tcnt        <= '0;
        end
        S_WAIT: begin
          r_tcnt <= w_tcnt_nxt;
          if (hit_valid) begin
            r_blk  <= hit;
            r_norm <= hit_norm;
          end else if (w_timeout) begin
            r_blk  <= BLOCK_AIR;
            r_norm <= '0;
          end
        end
        S_ADVANCE: begin
          if (!w_last) begin
            if (r_x < X_W'(WIDTH - 1)) begin
              r_x   <= r_x + 1'b1;
              r_dir <= fadd(r_dir, r_dx);
            end else begin
              r_x       <= '0;
              r_y       <= r_y + 1'b1;
              r_row_dir <= fadd(r_row_dir, r_dy);
              r_dir     <= fadd(r_row_dir, r_dy);
            end
          end
        end
        S_DONE:  busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Scoreboard bench for ray_dispatcher on a 4x2 screen with a stub VTU.
module tb_ray_dispatcher;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [95:0] cam_pos, cam_dir00, cam_dx, cam_dy;
  logic        vtu_rst;
  logic [95:0] ray_origin, ray_direction;
  logic [7:0]  hit;
  logic [95:0] hit_norm;
  logic        hit_valid;
  logic        busy, frame_done;

  ray_dispatcher_if #(.X_W(2), .Y_W(1), .COMP_W(32), .BLOCK_W(8)) pxi ();

  ray_dispatcher #(
    .WIDTH(W), .HEIGHT(H), .TIMEOUT(TO), .COMP_W(32), .BLOCK_W(8), .BLOCK_AIR(8'h00)
  ) dut (
    .clk_in(clk), .rst_in(rst), .start(start),
    .cam_pos(cam_pos), .cam_dir00(cam_dir00), .cam_dx(cam_dx), .cam_dy(cam_dy),
    .vtu_rst(vtu_rst), .ray_origin(ray_origin), .ray_direction(ray_direction),
    .hit(hit), .hit_norm(hit_norm), .hit_valid(hit_valid),
    .px(pxi.master), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [7:0]  blk;
    logic [95:0] norm;
    logic [95:0] dir;
    logic [95:0] orig;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   launch_cyc = 0;
  int   launch_idx = 0;
  int   hit_delay = 0;
  bit   inject_emit = 0;
  int   accepted_in_frame = 0;
  int   frames_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [95:0] exp_dir(input logic [95:0] d0, input logic [95:0] dx,
                                          input logic [95:0] dy, input int x, input int y);
    logic [95:0] r;
    r = '0;
    for (int i = 0; i < 3; i++)
      r[i*32 +: 32] = d0[i*32 +: 32] + 32'(x) * dx[i*32 +: 32] + 32'(y) * dy[i*32 +: 32];
    return r;
  endfunction

  // Stub VTU: one-cycle hit_valid 'hit_delay' cycles after vtu_rst (0 = never), hit = x+y.
  initial begin : stub
    int cnt;
    int cx;
    int cy;
    cnt = -1; cx = 0; cy = 0;
    hit_valid = 1'b0; hit = '0; hit_norm = '0;
    forever begin
      @(negedge clk);
      hit_valid = 1'b0;
      if (vtu_rst) begin
        cnt = 0; launch_cyc = cyc;
        cx = launch_idx % W; cy = launch_idx / W;
        launch_idx++;
      end else if (cnt >= 0) begin
        cnt++;
      end
      if (hit_delay != 0 && cnt == hit_delay) begin
        hit_valid = 1'b1; hit = 8'(cx + cy); hit_norm = {32'(cx), 32'(cy), 32'h7};
      end
      if (inject_emit && pxi.px_valid) begin
        hit_valid = 1'b1; hit = 8'hEE; hit_norm = '1;
      end
    end
  end

  // Backpressure: hold px_ready low across the EMIT of the 3rd launched ray, pixel (2,0).
  initial begin : ready_drv
    int nl;
    int n;
    nl = 0;
    pxi.px_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (vtu_rst && !rst) begin
        nl++;
        if (nl == 3) begin
          pxi.px_ready = 1'b0;
          n = 0;
          while (!pxi.px_valid && n < 40) begin @(posedge clk); #1; n++; end
          if (n >= 40) begin
            checks++; failures++;
            $display("FAIL stall_wait_valid actual=timeout required=px_valid");
          end
          repeat (5) begin
            @(posedge clk); #1;
            chk("stall_valid", 96'(pxi.px_valid), 96'(1));
            chk("stall_no_vtu_rst", 96'(vtu_rst), 96'(0));
            chk("stall_x", 96'(pxi.px_x), 96'(2));
            chk("stall_y", 96'(pxi.px_y), 96'(0));
            chk("stall_blk", 96'(pxi.px_block), 96'(2));
            chk("stall_norm", pxi.px_norm, {32'd2, 32'd0, 32'h7});
          end
          pxi.px_ready = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    bit   prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pxi.px_valid && !prev_v && sbq.size() > 0)
          chk("latency", 96'(cyc - launch_cyc), 96'(sbq[0].lat));
        if (pxi.px_valid && pxi.px_ready) begin
          if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_px actual=x%0d,y%0d required=none", pxi.px_x, pxi.px_y);
          end else begin
            e = sbq.pop_front();
            chk("px_x", 96'(pxi.px_x), 96'(e.x));
            chk("px_y", 96'(pxi.px_y), 96'(e.y));
            chk("px_block", 96'(pxi.px_block), 96'(e.blk));
            chk("px_norm", pxi.px_norm, e.norm);
            chk("ray_direction", ray_direction, e.dir);
            chk("ray_origin", ray_origin, e.orig);
            chk("busy_in_frame", 96'(busy), 96'(1));
          end
          accepted_in_frame++;
        end
        if (frame_done) begin
          chk("accepts_before_done", 96'(accepted_in_frame), 96'(W * H));
          frames_done++;
          accepted_in_frame = 0;
        end
      end
      prev_v = pxi.px_valid;
    end
  end

  task automatic start_frame(input logic [95:0] orig, input logic [95:0] d0,
                             input logic [95:0] dx, input logic [95:0] dy,
                             input int delay, input bit inject);
    exp_t e;
    hit_delay = delay; inject_emit = inject;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        e.x = x; e.y = y;
        e.blk  = (delay == 0) ? 8'h00 : 8'(x + y);
        e.norm = (delay == 0) ? 96'h0 : {32'(x), 32'(y), 32'h7};
        e.dir  = exp_dir(d0, dx, dy, x, y);
        e.orig = orig;
        e.lat  = (delay == 0) ? TO : delay + 1;
        sbq.push_back(e);
      end
    cam_pos = orig; cam_dir00 = d0; cam_dx = dx; cam_dy = dy;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cam_pos = {3{32'hDEAD_BEEF}}; cam_dir00 = {3{32'h1234_5678}};
    cam_dx = {3{32'h0BAD_0BAD}}; cam_dy = {3{32'h7777_0001}};
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!frame_done && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL %s actual=no_frame_done required=frame_done", nm);
    end
    @(negedge clk);
    chk({nm, "_busy_after"}, 96'(busy), 96'(0));
    chk({nm, "_sb_empty"}, 96'(sbq.size()), 96'(0));
  endtask

  initial begin : main
    int n;
    cam_pos = '0; cam_dir00 = '0; cam_dx = '0; cam_dy = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_vtu_rst", 96'(vtu_rst), 96'(0));
    chk("rst_origin", ray_origin, 96'h0);
    chk("rst_direction", ray_direction, 96'h0);
    chk("rst_px_valid", 96'(pxi.px_valid), 96'(0));
    chk("rst_px_x", 96'(pxi.px_x), 96'(0));
    chk("rst_px_y", 96'(pxi.px_y), 96'(0));
    chk("rst_px_block", 96'(pxi.px_block), 96'(0));
    chk("rst_px_norm", pxi.px_norm, 96'h0);
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_frame_done", 96'(frame_done), 96'(0));

    // Frame 1: dir00=(0,0,1.0), dx=(0.25,0,0), dy=(0,0.5,0) in Q16.16; hit 13 cycles after launch,
    // stall on (2,0), stray hit_valid during EMIT, stray start mid-frame.
    start_frame({32'h0001_0000, 32'h0002_0000, 32'h0003_0000},
                {32'h0, 32'h0, 32'h0001_0000},
                {32'h0000_4000, 32'h0, 32'h0},
                {32'h0, 32'h0000_8000, 32'h0}, 13, 1'b1);
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("frame1");
    chk("f1_dir_3_1", ray_direction, {32'h0000_C000, 32'h0000_8000, 32'h0001_0000});

    // Frame 2: never hits (timeout -> air), x component wraps past 0x7FFFFFFF.
    start_frame({32'hFFFF_0000, 32'h0, 32'h0000_0001},
                {32'h7FFF_8000, 32'hFFFF_0000, 32'h0001_0000},
                {32'h0000_4000, 32'h0, 32'h0},
                {32'h0, 32'h0000_8000, 32'h0}, 0, 1'b0);
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("frame2");
    chk("f2_dir_wrap", ray_direction, {32'h8000_4000, 32'hFFFF_8000, 32'h0001_0000});

    // Frame 3: hit lands on the timeout cycle (hit wins); reset during WAIT of pixel 3.
    launch_idx = 0;
    start_frame({32'h5, 32'h6, 32'h7},
                {32'h0, 32'h0, 32'h0001_0000},
                {32'h0000_4000, 32'h0, 32'h0},
                {32'h0, 32'h0000_8000, 32'h0}, 15, 1'b0);
    n = 0;
    while (launch_idx < 4 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL f3_reach_pixel3 actual=timeout required=launch");
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_vtu_rst", 96'(vtu_rst), 96'(0));
    chk("mid_rst_origin", ray_origin, 96'h0);
    chk("mid_rst_direction", ray_direction, 96'h0);
    chk("mid_rst_px_valid", 96'(pxi.px_valid), 96'(0));
    chk("mid_rst_px_x", 96'(pxi.px_x), 96'(0));
    chk("mid_rst_px_block", 96'(pxi.px_block), 96'(0));
    chk("mid_rst_px_norm", pxi.px_norm, 96'h0);
    chk("mid_rst_busy", 96'(busy), 96'(0));
    chk("mid_rst_frame_done", 96'(frame_done), 96'(0));
    rst = 1'b0;
    sbq.delete();
    accepted_in_frame = 0;
    launch_idx = 0;
    @(negedge clk);

    // Frame 4: clean restart from (0,0).
    start_frame({32'h0001_0000, 32'h0002_0000, 32'h0003_0000},
                {32'h0, 32'h0, 32'h0001_0000},
                {32'h0000_4000, 32'h0, 32'h0},
                {32'h0, 32'h0000_8000, 32'h0}, 13, 1'b0);
    wait_done("frame4");

    chk("frames_done_total", 96'(frames_done), 96'(3));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
